dds_profile_scheduler: RTL and testbench

//   Timed profile sequencer for the MAC_sync phase datapath.
//   - Buffers {time, freq, phase, rebase} commands.
//   - Applies each command when the system timestamp reaches its time.
//   - Drives the MAC A (timeoffset), B (freq), C (phase) and D (timestamp) inputs.
//   - Flags mul_result valid once the MAC pipeline holds data from a live profile.

---
 rtl/dds_sched_pkg.sv | 21 ++
 rtl/sched_cmd_fifo.sv | 54 +++++
 rtl/dds_profile_scheduler.sv | 98 +++++++++
 tb/tb_dds_profile_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sched_pkg.sv
// Shared types for the DDS profile scheduler: command record, widths and FSM states.
package dds_sched_pkg;

  localparam int TS_W = 48;
  localparam int PH_W = 14;

  // 'time' is a reserved word, so the apply time is held in at_time.
  typedef struct packed {
    logic [TS_W-1:0] at_time;
    logic [TS_W-1:0] freq;
    logic [PH_W-1:0] phase;
    logic            rebase;
  } dds_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    APPLY = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sched_cmd_fifo.sv
// First-word-fall-through command queue; clear empties it in one cycle and wins over push/pop.
module sched_cmd_fifo
  import dds_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  dds_cmd_t               din,
  output dds_cmd_t               dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  dds_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~clear & ~reset;
  assign pop_ok  = pop & ~empty & ~clear;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dds_profile_scheduler.sv
// Timed profile sequencer: queues {time, freq, phase, rebase} commands and loads the
// MAC A/B/C registers when the system timestamp reaches each command's time.
module dds_profile_scheduler
  import dds_sched_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MAC_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TS_W-1:0]        timestamp,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [TS_W-1:0]        cmd_time,
  input  logic [TS_W-1:0]        cmd_freq,
  input  logic [PH_W-1:0]        cmd_phase,
  input  logic                   cmd_rebase,
  input  logic                   flush,
  output logic [TS_W-1:0]        mac_A,
  output logic [TS_W-1:0]        mac_B,
  output logic [PH_W-1:0]        mac_C,
  output logic [TS_W-1:0]        mac_D,
  output logic                   out_valid,
  output logic                   applied,
  output logic                   late_error,
  output logic [$clog2(DEPTH):0] q_count
);

  sched_state_t       state;
  dds_cmd_t           push_cmd;
  dds_cmd_t           head;
  logic               full;
  logic               empty;
  logic               push;
  logic               fire;
  logic [TS_W-1:0]    diff;
  logic [MAC_LATENCY:0] vsr;

  assign cmd_ready = ~reset & ~flush & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign push_cmd  = '{at_time: cmd_time, freq: cmd_freq, phase: cmd_phase, rebase: cmd_rebase};

  sched_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (fire),
    .din   (push_cmd),
    .dout  (head),
    .count (q_count),
    .full  (full),
    .empty (empty)
  );

  // Signed modular distance, so a due time just past the 2^TS_W wrap still compares correctly.
  assign diff = timestamp - head.at_time;
  assign fire = (state == WAIT) & ~empty & ~diff[TS_W-1] & ~flush;

  // The commit happens on the WAIT cycle that finds the head due; APPLY is the cycle after it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (!empty) state <= WAIT;
        WAIT:    if (fire) state <= APPLY;
        APPLY:   state <= empty ? IDLE : WAIT;
        default: state <= IDLE;
      endcase
    end
  end

  assign applied   = (state == APPLY);
  assign out_valid = vsr[MAC_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      mac_A      <= '0;
      mac_B      <= '0;
      mac_C      <= '0;
      mac_D      <= '0;
      late_error <= 1'b0;
      vsr        <= '0;
    end else begin
      mac_D <= timestamp;
      if (flush) vsr <= '0;
      else       vsr <= {vsr[MAC_LATENCY-1:0], vsr[0] | fire};
      if (fire) begin
        mac_B <= head.freq;
        mac_C <= head.phase;
        if (head.rebase) mac_A <= head.at_time;
        if (diff != '0) late_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dds_profile_scheduler.sv
// Bench for dds_profile_scheduler: directed scenarios with literal pins plus a randomized run
// checked every cycle against a queue-based timing model.
module tb_dds_profile_scheduler;
  import dds_sched_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAC_LAT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [TS_W-1:0] timestamp = '0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [TS_W-1:0] cmd_time = '0;
  logic [TS_W-1:0] cmd_freq = '0;
  logic [PH_W-1:0] cmd_phase = '0;
  logic            cmd_rebase = 1'b0;
  logic            flush = 1'b0;
  logic [TS_W-1:0] mac_A, mac_B, mac_D;
  logic [PH_W-1:0] mac_C;
  logic            out_valid, applied, late_error;
  logic [2:0]      q_count;

  int              total = 0;
  int              bad = 0;
  logic [TS_W-1:0] ts_next = '0;

  always #5 clk = ~clk;

  dds_profile_scheduler #(.DEPTH(DEPTH), .MAC_LATENCY(MAC_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .timestamp  (timestamp),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_time   (cmd_time),
    .cmd_freq   (cmd_freq),
    .cmd_phase  (cmd_phase),
    .cmd_rebase (cmd_rebase),
    .flush      (flush),
    .mac_A      (mac_A),
    .mac_B      (mac_B),
    .mac_C      (mac_C),
    .mac_D      (mac_D),
    .out_valid  (out_valid),
    .applied    (applied),
    .late_error (late_error),
    .q_count    (q_count)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at ts=%0d", name, act, exp, timestamp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [TS_W-1:0] t, input logic [TS_W-1:0] f,
                               input logic [PH_W-1:0] p, input logic rb, input logic fl,
                               input logic rst);
    @(posedge clk);
    #1;
    timestamp  = ts_next;
    ts_next    = ts_next + 1'b1;
    cmd_valid  = v;
    cmd_time   = t;
    cmd_freq   = f;
    cmd_phase  = p;
    cmd_rebase = rb;
    flush      = fl;
    reset      = rst;
  endtask

  task automatic idleTo(input logic [TS_W-1:0] target);
    int guard = 0;
    while (timestamp != target && guard < 20000) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (timestamp != target) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_to: reached ts=%0d expected ts=%0d", timestamp, target);
    end
    @(negedge clk);
  endtask

  // Reference model: a command fires at cycle c when it is at the head, at least two cycles
  // have passed since it was pushed and since the previous fire, and (ts - time) is signed >= 0.
  dds_cmd_t        mq[$];
  int              mp[$];
  int              cyc = 0;
  int              last_fire = -100;
  int              live = -1;
  bit              m_known = 0;
  logic [TS_W-1:0] m_A = '0, m_B = '0, m_D = '0;
  logic [PH_W-1:0] m_C = '0;
  logic            m_late = 1'b0;

  always @(negedge clk) begin
    logic [TS_W-1:0] d;
    logic            fire;
    dds_cmd_t        h;
    dds_cmd_t        nc;
    cyc++;
    if (m_known) begin
      checkOutput("cmd_ready", 64'(cmd_ready), 64'(!reset && !flush && mq.size() < DEPTH));
      checkOutput("q_count", 64'(q_count), 64'(mq.size()));
      checkOutput("mac_A", 64'(mac_A), 64'(m_A));
      checkOutput("mac_B", 64'(mac_B), 64'(m_B));
      checkOutput("mac_C", 64'(mac_C), 64'(m_C));
      checkOutput("mac_D", 64'(mac_D), 64'(m_D));
      checkOutput("applied", 64'(applied), 64'(last_fire == cyc - 1));
      checkOutput("late_error", 64'(late_error), 64'(m_late));
      checkOutput("out_valid", 64'(out_valid), 64'(live >= 0 && cyc >= live + MAC_LAT + 1));
    end
    if (reset) begin
      mq.delete();
      mp.delete();
      m_A = '0; m_B = '0; m_C = '0; m_D = '0;
      m_late = 1'b0;
      last_fire = -100;
      live = -1;
      m_known = 1;
    end else if (m_known) begin
      fire = 1'b0;
      d = '0;
      if (flush) begin
        mq.delete();
        mp.delete();
        live = -1;
      end else begin
        if (mq.size() != 0 && cyc >= mp[0] + 2 && cyc >= last_fire + 2) begin
          d = timestamp - mq[0].at_time;
          fire = ~d[TS_W-1];
        end
        if (cmd_valid && mq.size() < DEPTH) begin
          nc = '{at_time: cmd_time, freq: cmd_freq, phase: cmd_phase, rebase: cmd_rebase};
          mq.push_back(nc);
          mp.push_back(cyc);
        end
        if (fire) begin
          h = mq.pop_front();
          void'(mp.pop_front());
          m_B = h.freq;
          m_C = h.phase;
          if (h.rebase) m_A = h.at_time;
          if (d != '0) m_late = 1'b1;
          last_fire = cyc;
          if (live < 0) live = cyc;
        end
      end
      m_D = timestamp;
    end
  end

  initial begin
    // Reset and an on-time rebase command at 100
    repeat (3) applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mac_A", 64'(mac_A), 64'd0);
    applyStimulus(1'b1, 48'd100, 48'h1000, 14'h155, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_ready_after_reset", 64'(cmd_ready), 64'd1);
    idleTo(48'd100);
    checkOutput("t1_applied_at_100", 64'(applied), 64'd0);
    idleTo(48'd101);
    checkOutput("t1_applied_at_101", 64'(applied), 64'd1);
    checkOutput("t1_mac_A", 64'(mac_A), 64'd100);
    checkOutput("t1_mac_B", 64'(mac_B), 64'h1000);
    checkOutput("t1_mac_C", 64'(mac_C), 64'h155);
    checkOutput("t1_mac_D", 64'(mac_D), 64'd100);
    checkOutput("t1_late", 64'(late_error), 64'd0);
    idleTo(48'd103);
    checkOutput("t1_valid_at_103", 64'(out_valid), 64'd0);
    idleTo(48'd104);
    checkOutput("t1_valid_at_104", 64'(out_valid), 64'd1);

    // Late command
    idleTo(48'd119);
    applyStimulus(1'b1, 48'd90, 48'h2222, 14'h3, 1'b0, 1'b0, 1'b0);
    idleTo(48'd123);
    checkOutput("t2_applied", 64'(applied), 64'd1);
    checkOutput("t2_late", 64'(late_error), 64'd1);
    checkOutput("t2_mac_A_kept", 64'(mac_A), 64'd100);
    checkOutput("t2_mac_B", 64'(mac_B), 64'h2222);

    // Fill the queue with four timed commands
    idleTo(48'd129);
    applyStimulus(1'b1, 48'd200, 48'h111, 14'h1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 48'd210, 48'h222, 14'h2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 48'd220, 48'h333, 14'h3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 48'd230, 48'h444, 14'h4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3_ready_full", 64'(cmd_ready), 64'd0);
    checkOutput("t3_q_count", 64'(q_count), 64'd4);
    idleTo(48'd200);
    checkOutput("t3_applied_200", 64'(applied), 64'd0);
    idleTo(48'd201);
    checkOutput("t3_applied_201", 64'(applied), 64'd1);
    checkOutput("t3_mac_A_201", 64'(mac_A), 64'd200);
    idleTo(48'd211);
    checkOutput("t3_mac_A_211", 64'(mac_A), 64'd200);
    checkOutput("t3_mac_B_211", 64'(mac_B), 64'h222);
    idleTo(48'd221);
    checkOutput("t3_mac_A_221", 64'(mac_A), 64'd220);
    idleTo(48'd231);
    checkOutput("t3_mac_A_231", 64'(mac_A), 64'd220);
    checkOutput("t3_mac_C_231", 64'(mac_C), 64'h4);
    checkOutput("t3_q_empty", 64'(q_count), 64'd0);

    // Apply time beyond the timestamp wrap
    ts_next = 48'hFFFF_FFFF_FFFA;
    applyStimulus(1'b1, 48'd3, 48'hABC, 14'h2AA, 1'b1, 1'b0, 1'b0);
    idleTo(48'hFFFF_FFFF_FFFF);
    checkOutput("t4_no_apply_pre_wrap", 64'(applied), 64'd0);
    idleTo(48'd3);
    checkOutput("t4_applied_at_3", 64'(applied), 64'd0);
    idleTo(48'd4);
    checkOutput("t4_applied_at_4", 64'(applied), 64'd1);
    checkOutput("t4_mac_A", 64'(mac_A), 64'd3);
    checkOutput("t4_mac_D", 64'(mac_D), 64'd3);

    // Flush with three queued and a simultaneous push
    idleTo(48'd9);
    applyStimulus(1'b1, 48'd1000, 48'h5001, 14'h11, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 48'd1001, 48'h5002, 14'h12, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 48'd1002, 48'h5003, 14'h13, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 48'd1003, 48'h5004, 14'h14, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t5_ready_in_flush", 64'(cmd_ready), 64'd0);
    checkOutput("t5_q_before", 64'(q_count), 64'd3);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5_q_after", 64'(q_count), 64'd0);
    checkOutput("t5_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_mac_A", 64'(mac_A), 64'd3);
    checkOutput("t5_mac_B", 64'(mac_B), 64'hABC);
    checkOutput("t5_mac_C", 64'(mac_C), 64'h2AA);

    // Reset while a command waits
    idleTo(48'd29);
    applyStimulus(1'b1, 48'd60, 48'h7777, 14'h77, 1'b1, 1'b0, 1'b0);
    idleTo(48'd40);
    checkOutput("t6_q_waiting", 64'(q_count), 64'd1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t6_mac_A", 64'(mac_A), 64'd0);
    checkOutput("t6_mac_B", 64'(mac_B), 64'd0);
    checkOutput("t6_late", 64'(late_error), 64'd0);
    checkOutput("t6_q_count", 64'(q_count), 64'd0);
    checkOutput("t6_ready", 64'(cmd_ready), 64'd0);
    idleTo(48'd61);
    checkOutput("t6_never_applied", 64'(applied), 64'd0);
    checkOutput("t6_mac_B_61", 64'(mac_B), 64'd0);

    // Randomized traffic across the timestamp wrap
    ts_next = 48'hFFFF_FFFF_FA24;
    for (int i = 0; i < 3000; i++) begin
      logic [TS_W-1:0] tt;
      logic [TS_W-1:0] ff;
      tt = ts_next + TS_W'($urandom_range(0, 60)) - TS_W'(12);
      ff = {$urandom, $urandom} & {TS_W{1'b1}};
      applyStimulus($urandom_range(0, 2) != 0, tt, ff, PH_W'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0,
                    $urandom_range(0, 299) == 0);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
